// File: rtl/lfsr_parity_checker.sv
// Receiver for the 7-bit LFSR/parity generator stream: checks parity, self-synchronises
// to the sequence, then flags sequence/parity errors and keeps a saturating error count.
module lfsr_parity_checker #(
  parameter int LOCK_N   = 4,   // 2..15
  parameter int UNLOCK_N = 3,   // 1..15
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             parity_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_V   = 4'(LOCK_N);
  localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_N);

  function automatic logic [6:0] lfsr_next(input logic [6:0] x);
    return {x[5:0], x[6] ^ x[5]};
  endfunction

  state_e           state_q, state_d;
  logic [6:0]       pred_q, pred_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             perr_q, perr_d;
  logic             serr_q, serr_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [6:0] d;
  logic [6:0] d_next;
  logic       par_ok;
  logic       d_zero;
  logic       d_miss;
  logic       cnt_inc;
  logic [3:0] match_inc;
  logic [3:0] miss_inc;

  // Odd parity over the full byte: parity bit is the complement of the data XOR.
  assign d         = in_data[6:0];
  assign d_next    = lfsr_next(d);
  assign par_ok    = ^in_data;
  assign d_zero    = (d == 7'd0);
  assign d_miss    = (d != pred_q);
  assign match_inc = match_cnt_q + 4'd1;
  assign miss_inc  = miss_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    perr_d      = 1'b0;
    serr_d      = 1'b0;
    cnt_inc     = 1'b0;

    if (in_valid) begin
      perr_d = ~par_ok;
      unique case (state_q)
        ST_SEARCH: begin
          // All-zero is the LFSR lockup value and can never seed a valid sequence.
          if (par_ok && !d_zero) begin
            pred_d      = d_next;
            match_cnt_d = 4'd1;
            state_d     = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (!par_ok || d_zero) begin
            state_d = ST_SEARCH;
          end else if (!d_miss) begin
            match_cnt_d = match_inc;
            pred_d      = d_next;
            if (match_inc == LOCK_V) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = 4'd0;
            end
          end else begin
            pred_d      = d_next;
            match_cnt_d = 4'd1;
          end
        end
        ST_LOCKED: begin
          // Flywheel: prediction advances on its own so a corrupted word cannot derail it.
          serr_d = d_miss;
          pred_d = lfsr_next(pred_q);
          if (!par_ok || d_miss) begin
            cnt_inc    = 1'b1;
            miss_cnt_d = miss_inc;
            if (miss_inc == UNLOCK_V) begin
              state_d     = ST_SEARCH;
              match_cnt_d = 4'd0;
            end
          end else begin
            miss_cnt_d = 4'd0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    // Clear beats a coincident increment; saturate at all-ones.
    err_cnt_d = err_cnt_q;
    if (clr_cnt)
      err_cnt_d = '0;
    else if (cnt_inc && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      pred_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign parity_err = perr_q;
  assign seq_err    = serr_q;
  assign err_count  = err_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_lfsr_parity_checker.sv
// Scoreboard bench for lfsr_parity_checker: a default instance and a CNT_W=4 instance
// share stimulus; a reference model pushes expected outputs per driven cycle.
module tb_lfsr_parity_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, clr_cnt;
  logic [7:0] in_data;

  logic        locked, parity_err, seq_err;
  logic [15:0] err_count;
  logic [1:0]  state;
  logic        locked4, parity_err4, seq_err4;
  logic [3:0]  err_count4;
  logic [1:0]  state4;

  lfsr_parity_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(locked), .parity_err(parity_err), .seq_err(seq_err),
    .err_count(err_count), .state(state)
  );

  lfsr_parity_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(locked4), .parity_err(parity_err4), .seq_err(seq_err4),
    .err_count(err_count4), .state(state4)
  );

  typedef struct packed {
    logic        lk;
    logic        pe;
    logic        se;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic        lk4;
    logic [1:0]  st4;
  } obs_t;

  obs_t exp_q[$];
  obs_t got, exp_o;
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  logic [1:0]  m_st;
  logic [6:0]  m_pred;
  logic [3:0]  m_match, m_miss;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt4;

  function automatic logic [6:0] nx(input logic [6:0] x);
    return {x[5:0], x[6] ^ x[5]};
  endfunction

  function automatic logic [7:0] gw(input logic [6:0] x);
    return {~(^x), x};
  endfunction

  function automatic obs_t sample();
    return '{lk: locked, pe: parity_err | parity_err4, se: seq_err | seq_err4, st: state,
             cnt: err_count, cnt4: err_count4, lk4: locked4, st4: state4};
  endfunction

  task automatic step(input logic r, input logic v, input logic [7:0] dat, input logic c);
    logic       pe, se, inc, pok;
    logic [6:0] dd;
    rst = r; in_valid = v; in_data = dat; clr_cnt = c;
    pe = 1'b0; se = 1'b0; inc = 1'b0;
    dd  = dat[6:0];
    pok = ^dat;
    if (r) begin
      m_st = 2'd0; m_pred = '0; m_match = '0; m_miss = '0; m_cnt = '0; m_cnt4 = '0;
    end else begin
      if (v) begin
        pe = !pok;
        case (m_st)
          2'd0: if (pok && dd != 7'd0) begin m_pred = nx(dd); m_match = 4'd1; m_st = 2'd1; end
          2'd1: begin
            if (!pok || dd == 7'd0) m_st = 2'd0;
            else if (dd == m_pred) begin
              m_match = m_match + 4'd1; m_pred = nx(dd);
              if (m_match == 4'd4) begin m_st = 2'd2; m_miss = 4'd0; end
            end else begin m_pred = nx(dd); m_match = 4'd1; end
          end
          default: begin
            se = (dd != m_pred);
            m_pred = nx(m_pred);
            if (!pok || se) begin
              inc = 1'b1; m_miss = m_miss + 4'd1;
              if (m_miss == 4'd3) begin m_st = 2'd0; m_match = 4'd0; end
            end else m_miss = 4'd0;
          end
        endcase
      end
      if (c) begin m_cnt = '0; m_cnt4 = '0; end
      else if (inc) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
      end
    end
    exp_q.push_back('{lk: m_st == 2'd2, pe: pe, se: se, st: m_st, cnt: m_cnt, cnt4: m_cnt4,
                      lk4: m_st == 2'd2, st4: m_st});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 8'h01, 1'b0);
      got = sample(); exp_o = exp_q.pop_front(); n_checks++;
      if (got !== exp_o) begin n_fail++; $display("FAIL reset[%0d]: got %h expected %h", i, got, exp_o); end
    end
    n_checks++;
    if ({locked, state, err_count, err_count4, parity_err} !== 24'd0) begin
      n_fail++; $display("FAIL reset_const: got %b/%0d/%0d expected all zero", locked, state, err_count);
    end
  endtask

  task automatic test_lock_acq();
    logic [7:0] w[4];
    logic [1:0] st_e[4];
    w = '{8'h01, 8'h02, 8'h04, 8'h08};
    st_e = '{2'd1, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, w[i], 1'b0);
      got = sample(); exp_o = exp_q.pop_front(); n_checks++;
      if (got !== exp_o) begin n_fail++; $display("FAIL lock_acq[%0d]: got %h expected %h", i, got, exp_o); end
      n_checks++;
      if (state !== st_e[i] || parity_err !== 1'b0 || seq_err !== 1'b0) begin
        n_fail++; $display("FAIL lock_acq_state[%0d]: got %0d expected %0d", i, state, st_e[i]);
      end
    end
    n_checks++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL lock_acq_locked: got locked=%b cnt=%0d expected 1/0", locked, err_count);
    end
  endtask

  task automatic test_parity_err();
    logic [7:0] w[2];
    w = '{8'h90, 8'h20};
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, w[i], 1'b0);
      got = sample(); exp_o = exp_q.pop_front(); n_checks++;
      if (got !== exp_o) begin n_fail++; $display("FAIL parity_err[%0d]: got %h expected %h", i, got, exp_o); end
      if (i == 0) begin
        n_checks++;
        if (parity_err !== 1'b1 || seq_err !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
          n_fail++; $display("FAIL parity_only: got pe=%b se=%b cnt=%0d lk=%b expected 1/0/1/1",
                             parity_err, seq_err, err_count, locked);
        end
      end
    end
  endtask

  task automatic test_flywheel_unlock();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h05, 1'b0);
      got = sample(); exp_o = exp_q.pop_front(); n_checks++;
      if (got !== exp_o) begin n_fail++; $display("FAIL flywheel[%0d]: got %h expected %h", i, got, exp_o); end
      n_checks++;
      if (seq_err !== 1'b1 || err_count !== 16'(2 + i)) begin
        n_fail++; $display("FAIL flywheel_pulse[%0d]: got se=%b cnt=%0d expected 1/%0d", i, seq_err, err_count, 2 + i);
      end
    end
    n_checks++;
    if (locked !== 1'b0 || state !== 2'd0) begin
      n_fail++; $display("FAIL unlock: got locked=%b state=%0d expected 0/0", locked, state);
    end
  endtask

  task automatic test_seed_zero();
    logic [7:0] w[6];
    logic [1:0] st_e[6];
    w = '{8'h80, 8'h81, 8'hC1, 8'h83, 8'h86, 8'h8C};
    st_e = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, w[i], 1'b0);
      got = sample(); exp_o = exp_q.pop_front(); n_checks++;
      if (got !== exp_o) begin n_fail++; $display("FAIL seed[%0d]: got %h expected %h", i, got, exp_o); end
      n_checks++;
      if (state !== st_e[i] || err_count !== 16'd4 || parity_err !== (i == 1)) begin
        n_fail++; $display("FAIL seed_state[%0d]: got st=%0d cnt=%0d pe=%b expected st=%0d cnt=4",
                           i, state, err_count, parity_err, st_e[i]);
      end
    end
  endtask

  task automatic test_idle_clear();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h55 ^ 8'(i), i == 3);
      got = sample(); exp_o = exp_q.pop_front(); n_checks++;
      if (got !== exp_o) begin n_fail++; $display("FAIL idle[%0d]: got %h expected %h", i, got, exp_o); end
    end
    n_checks++;
    if (locked !== 1'b1 || err_count !== 16'd0 || parity_err !== 1'b0) begin
      n_fail++; $display("FAIL idle_clear: got lk=%b cnt=%0d expected 1/0", locked, err_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 34; i++) begin
      step(1'b0, 1'b1, gw(m_pred) ^ ((i % 2 == 0) ? 8'h80 : 8'h00), 1'b0);
      got = sample(); exp_o = exp_q.pop_front(); n_checks++;
      if (got !== exp_o) begin n_fail++; $display("FAIL saturate[%0d]: got %h expected %h", i, got, exp_o); end
    end
    n_checks++;
    if (err_count4 !== 4'hF || err_count !== 16'd17 || locked4 !== 1'b1) begin
      n_fail++; $display("FAIL sat_hold: got cnt4=%0d cnt=%0d expected 15/17", err_count4, err_count);
    end
    step(1'b0, 1'b1, gw(m_pred) ^ 8'h80, 1'b1);
    got = sample(); exp_o = exp_q.pop_front(); n_checks++;
    if (got !== exp_o || err_count4 !== 4'd0 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL clr_wins: got %h cnt4=%0d expected %h cnt4=0", got, err_count4, exp_o);
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [6:0] s;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, gw(m_pred) ^ ((i % 2 == 1) ? 8'h80 : 8'h00), 1'b0);
      got = sample(); exp_o = exp_q.pop_front(); n_checks++;
      if (got !== exp_o) begin n_fail++; $display("FAIL prelock[%0d]: got %h expected %h", i, got, exp_o); end
    end
    n_checks++;
    if (err_count !== 16'd5 || locked !== 1'b1) begin
      n_fail++; $display("FAIL prelock_cnt: got cnt=%0d lk=%b expected 5/1", err_count, locked);
    end
    step(1'b1, 1'b1, gw(m_pred), 1'b0);
    got = sample(); exp_o = exp_q.pop_front(); n_checks++;
    if (got !== exp_o || locked !== 1'b0 || state !== 2'd0 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL midreset: got %h expected %h", got, exp_o);
    end
    s = 7'h11;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, gw(s), 1'b0);
      s = nx(s);
      got = sample(); exp_o = exp_q.pop_front(); n_checks++;
      if (got !== exp_o || locked !== (i == 3)) begin
        n_fail++; $display("FAIL relock[%0d]: got %h lk=%b expected %h", i, got, locked, exp_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       w = 8'($urandom);
        1:       w = gw(m_pred) ^ 8'h80;
        2:       w = gw(m_pred) ^ 8'h01;
        default: w = gw(m_pred);
      endcase
      step($urandom_range(0, 60) == 0, $urandom_range(0, 4) != 0, w, $urandom_range(0, 30) == 0);
      got = sample(); exp_o = exp_q.pop_front(); n_checks++;
      if (got !== exp_o) begin n_fail++; $display("FAIL b2b[%0d]: got %h expected %h", i, got, exp_o); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_lock_acq();
    test_parity_err();
    test_flywheel_unlock();
    test_seed_zero();
    test_idle_clear();
    test_saturation();
    test_reset_mid_lock();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
